// File: rtl/deser_pkg.sv
// Shared types for the deserializer receive controller and its byte queue.
package deser_pkg;

  localparam int unsigned DATA_W = 8;

  typedef enum logic [1:0] {IDLE, LOAD, ACK, WAIT_CLR} ctrl_state_t;

  typedef logic [DATA_W-1:0] byte_t;

endpackage

// File: rtl/byte_fifo.sv
// Show-ahead byte queue: the head is visible on head_o whenever non-empty, 0 otherwise.
module byte_fifo
  import deser_pkg::*;
#(
  parameter int unsigned DEPTH = 8
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   push_i,
  input  byte_t                  wdata_i,
  input  logic                   pop_i,
  output byte_t                  head_o,
  output logic [$clog2(DEPTH):0] len_o,
  output logic                   full_o,
  output logic                   empty_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  byte_t          mem_q [DEPTH];
  logic [AW-1:0]  wr_q, wr_d;
  logic [AW-1:0]  rd_q, rd_d;
  logic [LW-1:0]  len_q, len_d;
  logic           pop_ok;

  // Pops on an empty queue are ignored; pushes are never issued while full.
  always_comb begin
    pop_ok = pop_i && (len_q != '0);
    wr_d   = push_i ? wr_q + AW'(1) : wr_q;
    rd_d   = pop_ok ? rd_q + AW'(1) : rd_q;
    len_d  = len_q;
    if (push_i && !pop_ok) begin
      len_d = len_q + LW'(1);
    end else if (!push_i && pop_ok) begin
      len_d = len_q - LW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      len_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      len_q <= len_d;
    end
  end

  // Storage needs no reset; the pointers alone define valid contents.
  always_ff @(posedge clk_i) begin
    if (push_i) begin
      mem_q[wr_q] <= wdata_i;
    end
  end

  assign empty_o = (len_q == '0);
  assign full_o  = (len_q == LW'(DEPTH));
  assign len_o   = len_q;
  assign head_o  = empty_o ? '0 : mem_q[rd_q];

endmodule

// File: rtl/deser_rx_ctrl.sv
// Drains bytes from the deserializer into a byte queue with a one-cycle ack,
// stalling on a full queue and dropping the byte after a bounded wait.
module deser_rx_ctrl
  import deser_pkg::*;
#(
  parameter int unsigned DEPTH     = 8,
  parameter int unsigned STALL_MAX = 16,
  parameter int unsigned CNT_W     = 8
) (
  input  logic                   clock_100k,
  input  logic                   reset,
  input  byte_t                  des_data,
  input  logic                   des_ready,
  output logic                   des_ack,
  input  logic                   deq_in,
  output byte_t                  data_out,
  output logic [$clog2(DEPTH):0] len_out,
  output logic                   full,
  output logic                   empty,
  output logic                   overflow,
  output logic [CNT_W-1:0]       drop_cnt
);

  localparam int unsigned SW = $clog2(STALL_MAX + 1);

  ctrl_state_t       state_q, state_d;
  logic [SW-1:0]     stall_q, stall_d;
  logic              ack_q, ack_d;
  logic              ovf_q, ovf_d;
  logic [CNT_W-1:0]  drop_cnt_q, drop_cnt_d;
  logic              stall_last;
  logic              push;
  logic              drop;

  assign stall_last = (stall_q == SW'(STALL_MAX - 1));

  always_ff @(posedge clock_100k) begin
    if (reset) begin
      state_q    <= IDLE;
      stall_q    <= '0;
      ack_q      <= 1'b0;
      ovf_q      <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      stall_q    <= stall_d;
      ack_q      <= ack_d;
      ovf_q      <= ovf_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  // Next state and stall counting; the stall counter only runs while IDLE waits on a full queue.
  always_comb begin
    state_d = state_q;
    stall_d = stall_q;
    case (state_q)
      IDLE: begin
        if (des_ready) begin
          if (!full) begin
            state_d = LOAD;
            stall_d = '0;
          end else if (stall_last) begin
            state_d = ACK;
            stall_d = '0;
          end else begin
            stall_d = stall_q + SW'(1);
          end
        end else begin
          stall_d = '0;
        end
      end
      LOAD:     state_d = ACK;
      ACK:      state_d = WAIT_CLR;
      WAIT_CLR: if (!des_ready) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // Outputs: ack is registered from the next state so it is high exactly in ACK.
  always_comb begin
    push       = (state_q == LOAD);
    drop       = (state_q == IDLE) && des_ready && full && stall_last;
    ack_d      = (state_d == ACK);
    ovf_d      = ovf_q | drop;
    drop_cnt_d = drop_cnt_q;
    if (drop && (drop_cnt_q != '1)) begin
      drop_cnt_d = drop_cnt_q + CNT_W'(1);
    end
  end

  byte_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk_i   (clock_100k),
    .rst_i   (reset),
    .push_i  (push),
    .wdata_i (des_data),
    .pop_i   (deq_in),
    .head_o  (data_out),
    .len_o   (len_out),
    .full_o  (full),
    .empty_o (empty)
  );

  assign des_ack  = ack_q;
  assign overflow = ovf_q;
  assign drop_cnt = drop_cnt_q;

endmodule

// File: tb/tb_deser_rx_ctrl.sv
// Self-checking bench for deser_rx_ctrl: directed table, corner sequences, random traffic vs a queue model.
module tb_deser_rx_ctrl;

  localparam int unsigned DEPTH     = 8;
  localparam int unsigned STALL_MAX = 16;
  localparam int unsigned CNT_W     = 8;

  bit          clk = 1'b0;
  logic        reset;
  logic [7:0]  des_data;
  logic        des_ready;
  logic        des_ack;
  logic        deq_in;
  logic [7:0]  data_out;
  logic [3:0]  len_out;
  logic        full;
  logic        empty;
  logic        overflow;
  logic [7:0]  drop_cnt;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  deser_rx_ctrl #(.DEPTH(DEPTH), .STALL_MAX(STALL_MAX), .CNT_W(CNT_W)) dut (
    .clock_100k (clk),
    .reset      (reset),
    .des_data   (des_data),
    .des_ready  (des_ready),
    .des_ack    (des_ack),
    .deq_in     (deq_in),
    .data_out   (data_out),
    .len_out    (len_out),
    .full       (full),
    .empty      (empty),
    .overflow   (overflow),
    .drop_cnt   (drop_cnt)
  );

  // Reference model: byte queue plus handshake timing derived from the protocol rules.
  logic [7:0] q[$];
  bit         m_hold;   // byte acked, waiting for the deserializer to release ready
  int         m_t;      // 1: push + ack due at next edge, 2: ack showing now
  bit         m_ack;
  int         m_stall;
  bit         m_ovf;
  int         m_drops;

  task automatic model_edge(input bit rst, input bit rdy, input logic [7:0] d, input bit deq);
    bit full_pre, empty_pre, hold_pre;
    int t_pre;
    if (rst) begin
      q.delete();
      m_hold = 0; m_t = 0; m_ack = 0; m_stall = 0; m_ovf = 0; m_drops = 0;
      return;
    end
    full_pre  = (q.size() == DEPTH);
    empty_pre = (q.size() == 0);
    hold_pre  = m_hold;
    t_pre     = m_t;
    m_ack     = 0;
    if (deq && !empty_pre) void'(q.pop_front());
    if (t_pre == 1) begin
      q.push_back(d);
      m_ack = 1;
      m_t   = 2;
    end else if (t_pre == 2) begin
      m_t    = 0;
      m_hold = 1;
    end else if (hold_pre) begin
      if (!rdy) m_hold = 0;
    end else if (rdy) begin
      if (!full_pre) begin
        m_t     = 1;
        m_stall = 0;
      end else if (m_stall == STALL_MAX - 1) begin
        m_stall = 0;
        m_ack   = 1;
        m_t     = 2;
        m_ovf   = 1;
        if (m_drops < (1 << CNT_W) - 1) m_drops++;
      end else begin
        m_stall++;
      end
    end else begin
      m_stall = 0;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_model();
    logic [7:0] head;
    head = (q.size() != 0) ? q[0] : 8'h00;
    chk("ack",      32'(des_ack),  32'(m_ack));
    chk("len",      32'(len_out),  32'(q.size()));
    chk("head",     32'(data_out), 32'(head));
    chk("full",     32'(full),     32'(q.size() == DEPTH));
    chk("empty",    32'(empty),    32'(q.size() == 0));
    chk("overflow", 32'(overflow), 32'(m_ovf));
    chk("drop_cnt", 32'(drop_cnt), 32'(m_drops));
  endtask

  // One clock: drive at the falling edge, check 1 ns after the rising edge.
  task automatic step(input bit rst, input bit rdy, input logic [7:0] d, input bit deq);
    reset     = rst;
    des_ready = rdy;
    des_data  = d;
    deq_in    = deq;
    @(posedge clk);
    model_edge(rst, rdy, d, deq);
    #1;
    compare_model();
    @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] d);
    bit got;
    got = 0;
    for (int i = 0; i < 40 && !got; i++) begin
      step(0, 1, d, 0);
      if (des_ack) got = 1;
    end
    if (!got) chk("send_timeout", 32'(0), 32'(1));
    step(0, 0, d, 0);
    step(0, 0, d, 0);
  endtask

  task automatic fill(input logic [7:0] base, input int n);
    for (int i = 0; i < n; i++) send_byte(base + 8'(i));
  endtask

  typedef struct {
    bit         rst;
    bit         rdy;
    logic [7:0] d;
    bit         deq;
    bit         e_ack;
    int         e_len;
    logic [7:0] e_head;
    bit         e_empty;
    bit         e_full;
  } vec_t;

  vec_t tbl[10];

  initial begin
    #1ms;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    bit got;
    int cnt;
    bit r;
    logic [7:0] dd;
    int cool;
    logic [7:0] e;

    tbl[0] = '{0, 1, 8'hAD, 0, 0, 0, 8'h00, 1, 0};
    tbl[1] = '{0, 1, 8'hAD, 0, 1, 1, 8'hAD, 0, 0};
    tbl[2] = '{0, 1, 8'hAD, 0, 0, 1, 8'hAD, 0, 0};
    tbl[3] = '{0, 1, 8'hAD, 0, 0, 1, 8'hAD, 0, 0};
    tbl[4] = '{0, 0, 8'hAD, 0, 0, 1, 8'hAD, 0, 0};
    tbl[5] = '{0, 0, 8'hAD, 0, 0, 1, 8'hAD, 0, 0};
    tbl[6] = '{0, 0, 8'h00, 1, 0, 0, 8'h00, 1, 0};
    tbl[7] = '{0, 0, 8'h00, 1, 0, 0, 8'h00, 1, 0};
    tbl[8] = '{0, 1, 8'h3C, 0, 0, 0, 8'h00, 1, 0};
    tbl[9] = '{0, 1, 8'h3C, 1, 1, 1, 8'h3C, 0, 0};

    reset = 1; des_ready = 0; des_data = 0; deq_in = 0;
    @(negedge clk);
    step(1, 0, 8'h00, 0);
    chk("rst_len",   32'(len_out),  32'(0));
    chk("rst_empty", 32'(empty),    32'(1));
    chk("rst_ack",   32'(des_ack),  32'(0));
    chk("rst_head",  32'(data_out), 32'(0));

    // Single byte handshake, WAIT_CLR hold, and pops on empty.
    for (int i = 0; i < 10; i++) begin
      step(tbl[i].rst, tbl[i].rdy, tbl[i].d, tbl[i].deq);
      chk($sformatf("tbl%0d_ack", i),   32'(des_ack),  32'(tbl[i].e_ack));
      chk($sformatf("tbl%0d_len", i),   32'(len_out),  32'(tbl[i].e_len));
      chk($sformatf("tbl%0d_head", i),  32'(data_out), 32'(tbl[i].e_head));
      chk($sformatf("tbl%0d_empty", i), 32'(empty),    32'(tbl[i].e_empty));
      chk($sformatf("tbl%0d_full", i),  32'(full),     32'(tbl[i].e_full));
    end
    step(0, 0, 8'h3C, 0);
    step(0, 0, 8'h3C, 0);

    // Fill to full, then drain in order.
    step(1, 0, 8'h00, 0);
    fill(8'h01, 8);
    chk("fill_full", 32'(full),    32'(1));
    chk("fill_len",  32'(len_out), 32'(8));
    for (int i = 0; i < 8; i++) begin
      chk("drain_head", 32'(data_out), 32'(i + 1));
      step(0, 0, 8'h00, 1);
    end
    chk("drain_empty", 32'(empty),    32'(1));
    chk("drain_head0", 32'(data_out), 32'(0));

    // Full queue with no pops: byte dropped after the stall budget.
    fill(8'h01, 8);
    got = 0; cnt = 0;
    for (int i = 1; i <= 40 && !got; i++) begin
      step(0, 1, 8'h99, 0);
      if (des_ack) begin got = 1; cnt = i; end
    end
    chk("drop_latency", 32'(cnt),      32'(STALL_MAX));
    chk("drop_ovf",     32'(overflow), 32'(1));
    chk("drop_cnt1",    32'(drop_cnt), 32'(1));
    chk("drop_len",     32'(len_out),  32'(8));
    step(0, 0, 8'h99, 0);
    step(0, 0, 8'h99, 0);
    for (int i = 0; i < 8; i++) begin
      chk("drop_drain", 32'(data_out), 32'(i + 1));
      step(0, 0, 8'h00, 1);
    end

    // Pop during a stall frees a slot and the byte is accepted.
    step(1, 0, 8'h00, 0);
    fill(8'h01, 8);
    for (int i = 0; i < 5; i++) step(0, 1, 8'h99, 0);
    step(0, 1, 8'h99, 1);
    got = 0;
    for (int i = 0; i < 10 && !got; i++) begin
      step(0, 1, 8'h99, 0);
      if (des_ack) got = 1;
    end
    chk("relief_ack",  32'(got),      32'(1));
    chk("relief_ovf",  32'(overflow), 32'(0));
    chk("relief_drop", 32'(drop_cnt), 32'(0));
    chk("relief_len",  32'(len_out),  32'(8));
    step(0, 0, 8'h99, 0);
    step(0, 0, 8'h99, 0);
    for (int i = 0; i < 8; i++) begin
      e = (i < 7) ? 8'(i + 2) : 8'h99;
      chk("relief_drain", 32'(data_out), 32'(e));
      step(0, 0, 8'h00, 1);
    end

    // Push and pop in the same LOAD cycle.
    step(1, 0, 8'h00, 0);
    fill(8'h10, 3);
    step(0, 1, 8'h5A, 0);
    step(0, 1, 8'h5A, 1);
    chk("pp_len",  32'(len_out),  32'(3));
    chk("pp_head", 32'(data_out), 32'(8'h11));
    step(0, 0, 8'h5A, 0);
    step(0, 0, 8'h5A, 0);
    for (int i = 0; i < 3; i++) begin
      e = (i == 0) ? 8'h11 : (i == 1) ? 8'h12 : 8'h5A;
      chk("pp_drain", 32'(data_out), 32'(e));
      step(0, 0, 8'h00, 1);
    end
    step(0, 0, 8'h00, 1);
    chk("pp_empty_len", 32'(len_out), 32'(0));

    // Reset during ACK with len 5 and overflow set; byte recaptured afterwards.
    step(1, 0, 8'h00, 0);
    fill(8'h01, 8);
    got = 0;
    for (int i = 0; i < 40 && !got; i++) begin
      step(0, 1, 8'h99, 0);
      if (des_ack) got = 1;
    end
    step(0, 0, 8'h99, 0);
    step(0, 0, 8'h99, 0);
    for (int i = 0; i < 4; i++) step(0, 0, 8'h00, 1);
    step(0, 1, 8'h77, 0);
    step(0, 1, 8'h77, 0);
    chk("r6_pre_ack", 32'(des_ack),  32'(1));
    chk("r6_pre_len", 32'(len_out),  32'(5));
    chk("r6_pre_ovf", 32'(overflow), 32'(1));
    step(1, 1, 8'h77, 0);
    chk("r6_ack",   32'(des_ack),  32'(0));
    chk("r6_len",   32'(len_out),  32'(0));
    chk("r6_empty", 32'(empty),    32'(1));
    chk("r6_ovf",   32'(overflow), 32'(0));
    chk("r6_drop",  32'(drop_cnt), 32'(0));
    step(0, 1, 8'h77, 0);
    step(0, 1, 8'h77, 0);
    chk("r6_recap_len",  32'(len_out),  32'(1));
    chk("r6_recap_head", 32'(data_out), 32'(8'h77));
    step(0, 0, 8'h77, 0);
    step(0, 0, 8'h77, 0);

    // Random traffic; alternating pop rates force both stalls with relief and drops.
    step(1, 0, 8'h00, 0);
    r = 0; dd = 8'h00; cool = 0;
    for (int c = 0; c < 4000; c++) begin
      bit rst, deq;
      rst = ($urandom_range(0, 1499) == 0);
      deq = ((c / 500) % 2 == 0) ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 11) == 0);
      step(rst, r, dd, deq);
      if (des_ack) begin
        r = 0;
        cool = 2;
      end else if (cool > 0) begin
        cool--;
      end else if (!r && $urandom_range(0, 2) == 0) begin
        r  = 1;
        dd = 8'($urandom);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
